// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core types, data-memory responder state encoding and
//                data-memory address checking helper.
//  Revision    : 1.0 - adds dmem_state_t and dmem_addr_err
// ============================================================================
package core_pkg;

   typedef enum logic [2:0] {
      OP_ALU,
      OP_LDM,
      OP_STM,
      OP_BRANCH,
      OP_JUMP
   } op_type;

   typedef enum logic [1:0] {
      RES_ALU,
      RES_MEM,
      RES_PC4
   } result_src_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam int DMEM_WORD_BYTES = 4;

   // Misaligned, or any address bit above the array's byte range is set.
   function automatic logic dmem_addr_err(input logic [31:0] addr, input int unsigned aw);
      logic [31:0] w_hi;
      w_hi = addr >> (aw + 32'd2);
      return (addr[1:0] != 2'b00) || (w_hi != 32'd0);
   endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Single-port word-addressed synchronous RAM, registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] idx,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

   // Read-first: a read on the write edge returns the previous contents.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[idx] <= wdata;
      end
      rdata <= r_mem[idx];
   end

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Load/store responder with programmable wait states, one-cycle
//                response pulse and misaligned/out-of-range error reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
   import core_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   input  logic                  req_write_i,
   input  logic [31:0]           req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  req_ready_o,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  busy_o
);

   localparam int         c_BYTE_LSB  = $clog2(DMEM_WORD_BYTES);
   localparam logic [3:0] c_WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   dmem_state_t           r_state;
   dmem_state_t           w_next_state;
   logic [3:0]            r_cnt;
   logic                  r_write;
   logic                  r_err;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [DATA_WIDTH-1:0] r_wdata;

   logic                  w_accept;
   logic                  w_enter_resp;
   logic                  w_write;
   logic                  w_err;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_we;
   logic [DATA_WIDTH-1:0] w_rdata;

   assign w_accept = (r_state == IDLE) && req_valid_i && !rst;

   // With zero wait states the array is accessed on the accept edge itself,
   // so the live request is steered to the array while idle.
   assign w_write = (r_state == IDLE) ? req_write_i : r_write;
   assign w_err   = (r_state == IDLE) ? dmem_addr_err(req_addr_i, ADDR_WIDTH) : r_err;
   assign w_idx   = (r_state == IDLE) ? req_addr_i[ADDR_WIDTH+c_BYTE_LSB-1:c_BYTE_LSB] : r_idx;
   assign w_wdata = (r_state == IDLE) ? req_wdata_i : r_wdata;

   assign w_enter_resp = (w_next_state == RESP) && (r_state != RESP) && !rst;
   assign w_we         = w_enter_resp && w_write && !w_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      req_ready_o  = 1'b0;
      rsp_valid_o  = 1'b0;
      rsp_err_o    = 1'b0;
      rsp_rdata_o  = '0;
      busy_o       = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            req_ready_o = 1'b1;
            if (w_accept) begin
               w_next_state = (WAIT_STATES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_next_state = RESP;
            end
         end
         RESP: begin
            rsp_valid_o  = 1'b1;
            rsp_err_o    = r_err;
            rsp_rdata_o  = (r_write || r_err) ? '0 : w_rdata;
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= 4'd0;
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
      end else begin
         if (w_accept) begin
            r_cnt   <= c_WAIT_INIT;
            r_write <= req_write_i;
            r_err   <= dmem_addr_err(req_addr_i, ADDR_WIDTH);
            r_idx   <= req_addr_i[ADDR_WIDTH+c_BYTE_LSB-1:c_BYTE_LSB];
            r_wdata <= req_wdata_i;
         end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   dmem_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_array (
      .clk   (clk),
      .we    (w_we),
      .idx   (w_idx),
      .wdata (w_wdata),
      .rdata (w_rdata)
   );

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed bench for dmem_responder (WAIT_STATES=2 and 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr  = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        valid2 = 1'b0;
   logic        valid0 = 1'b0;

   logic        ready2, rv2, err2, busy2;
   logic [31:0] rd2;
   logic        ready0, rv0, err0, busy0;
   logic [31:0] rd0;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(valid2), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .req_ready_o(ready2), .rsp_valid_o(rv2), .rsp_rdata_o(rd2), .rsp_err_o(err2), .busy_o(busy2)
   );

   dmem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid_i(valid0), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .req_ready_o(ready0), .rsp_valid_o(rv0), .rsp_rdata_o(rd0), .rsp_err_o(err0), .busy_o(busy0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One request on the selected DUT (s=1 -> zero-wait instance); latency is
   // counted in edges from the accept edge to the edge sampling the response.
   task automatic xact(input bit s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
      int t;
      rd  = 32'h0;
      er  = 1'b0;
      lat = -1;
      @(negedge clk);
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      if (s) valid0 = 1'b1; else valid2 = 1'b1;
      t = 0;
      while (!(s ? ready0 : ready2) && t < 20) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      valid0 = 1'b0;
      valid2 = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (s ? rv0 : rv2) begin
            lat = i;
            rd  = s ? rd0 : rd2;
            er  = s ? err0 : err2;
            break;
         end
      end
      @(negedge clk);
      check("pulse_end", {31'h0, (s ? rv0 : rv2)}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          n_acc, n_rsp, ready_bad, seen;
      int          acc [3];

      // Reset held with a pending (out-of-range) read request.
      #1 rst = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h1000;
      valid2    = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_ready", {31'h0, ready2}, 32'h1);
         check("rst_rvalid", {31'h0, rv2}, 32'h0);
         check("rst_busy", {31'h0, busy2}, 32'h0);
      end
      check("rst_rdata", rd2, 32'h0);
      check("rst_err", {31'h0, err2}, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1 valid2 = 1'b0;
      check("rel_accept", {31'h0, busy2}, 32'h1);
      repeat (2) @(negedge clk);
      @(negedge clk);
      check("rel_rsp_valid", {31'h0, rv2}, 32'h1);
      check("rel_rsp_err", {31'h0, err2}, 32'h1);
      @(negedge clk);

      // Write then read back, latency 3 with two wait states.
      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
      check("wr_lat", 32'(lat), 32'd3);
      check("wr_rdata", rd, 32'h0);
      check("wr_err", {31'h0, er}, 32'h0);
      xact(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
      check("rd_lat", 32'(lat), 32'd3);
      check("rd_rdata", rd, 32'hDEADBEEF);
      check("rd_err", {31'h0, er}, 32'h0);

      // Misaligned write must not disturb word 0x10.
      xact(0, 1'b1, 32'h11, 32'hCAFEF00D, rd, er, lat);
      check("mis_err", {31'h0, er}, 32'h1);
      check("mis_rdata", rd, 32'h0);
      xact(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
      check("mis_keep", rd, 32'hDEADBEEF);

      // Range boundary.
      xact(0, 1'b0, 32'h1000, 32'h0, rd, er, lat);
      check("oor_err", {31'h0, er}, 32'h1);
      check("oor_rdata", rd, 32'h0);
      xact(0, 1'b1, 32'hFFC, 32'h0BADC0DE, rd, er, lat);
      check("top_wr_err", {31'h0, er}, 32'h0);
      xact(0, 1'b0, 32'hFFC, 32'h0, rd, er, lat);
      check("top_rd_err", {31'h0, er}, 32'h0);
      check("top_rd_data", rd, 32'h0BADC0DE);

      // Back-to-back reads with valid held high.
      @(negedge clk);
      req_write = 1'b0;
      req_addr  = 32'h10;
      valid2    = 1'b1;
      n_acc = 0; n_rsp = 0; ready_bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (rv2) begin
            n_rsp++;
            check("b2b_data", rd2, 32'hDEADBEEF);
         end
         if (busy2 && ready2) ready_bad++;
         if (ready2 && valid2 && n_acc < 3) begin
            acc[n_acc] = cyc;
            n_acc++;
            if (n_acc == 3) begin
               @(posedge clk);
               #1 valid2 = 1'b0;
            end
         end
         @(negedge clk);
      end
      check("b2b_accepts", 32'(n_acc), 32'd3);
      check("b2b_gap1", 32'(acc[1] - acc[0]), 32'd4);
      check("b2b_gap2", 32'(acc[2] - acc[1]), 32'd4);
      check("b2b_rsps", 32'(n_rsp), 32'd3);
      check("b2b_ready_busy", 32'(ready_bad), 32'd0);

      // Abort an in-flight write with reset.
      xact(0, 1'b1, 32'h20, 32'h55AA55AA, rd, er, lat);
      check("pre_wr_err", {31'h0, er}, 32'h0);
      @(negedge clk);
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h12345678;
      valid2    = 1'b1;
      @(posedge clk);
      #1 valid2 = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'h0, busy2}, 32'h1);
      rst = 1'b1;
      #1;
      check("abort_idle", {31'h0, busy2}, 32'h0);
      check("abort_ready", {31'h0, ready2}, 32'h1);
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (rv2) seen++;
      end
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rv2) seen++;
      end
      check("abort_norsp", 32'(seen), 32'd0);
      xact(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
      check("abort_keep", rd, 32'h55AA55AA);

      // Zero-wait-state instance.
      xact(1, 1'b1, 32'h20, 32'h12345678, rd, er, lat);
      check("ws0_wr_lat", 32'(lat), 32'd1);
      check("ws0_wr_err", {31'h0, er}, 32'h0);
      check("ws0_wr_rdata", rd, 32'h0);
      xact(1, 1'b0, 32'h20, 32'h0, rd, er, lat);
      check("ws0_rd_lat", 32'(lat), 32'd1);
      check("ws0_rd_data", rd, 32'h12345678);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_dmem_responder
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder on the core's load/store port. It accepts STM (write) and LDM (read) requests issued by the decode/execute path on a valid/ready handshake. It applies a configurable number of wait states and returns a one-cycle response carrying read data or an error flag. Storage is an internal word-addressed single-port array; the core stalls on req_ready_o and rsp_valid_o.

Parameters:
ADDR_WIDTH, 10, log2 of array depth in 32-bit words (1024 words = 4 KiB)
DATA_WIDTH, 32, word width; fixed at 32 for this core
WAIT_STATES, 2, extra cycles between accept and response (0..15)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid_i  input  1  request present (driven from mem_write or LDM decode)
req_write_i  input  1  1 = STM write, 0 = LDM read
req_addr_i  input  32  byte address (ALU result)
req_wdata_i  input  32  store data (rs2)
req_ready_o  output  1  responder can accept a request this cycle
rsp_valid_o  output  1  one-cycle response pulse
rsp_rdata_o  output  32  load data; 0 for writes and errors
rsp_err_o  output  1  misaligned or out-of-range access, valid with rsp_valid_o
busy_o  output  1  request in flight (state != IDLE)

Behaviour:
- Reset (async, rst=1): state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, busy_o=0, wait counter=0. Array contents are not reset and are undefined at power-up.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - Handshake = req_valid_i & req_ready_o at a rising edge.
  - On handshake: capture addr, wdata and write flag; compute err.
  - Next state is WAIT with counter = WAIT_STATES-1 if WAIT_STATES>0, else RESP.
- WAIT:
  - req_ready_o=0.
  - Counter decrements each cycle; move to RESP when the counter reaches 0.
- RESP:
  - rsp_valid_o=1 for exactly this cycle; req_ready_o=0.
  - Unconditional return to IDLE. There is no response backpressure; the core must sample the response in this cycle.
- Latency: rsp_valid_o asserts WAIT_STATES+1 cycles after the accept edge. Throughput is one request per WAIT_STATES+2 cycles.
- Error:
  - err = (addr[1:0] != 0) | (addr[31:ADDR_WIDTH+2] != 0).
  - On err: no array write occurs; rsp_rdata_o=0 and rsp_err_o=1.
- Array access:
  - Word index = addr[ADDR_WIDTH+1:2].
  - A write commits on the edge entering RESP.
  - Read data is registered on the edge entering RESP and held in rsp_rdata_o during RESP.
- Write response: rsp_rdata_o=0, rsp_err_o=0 unless err.
- Outside RESP: rsp_rdata_o and rsp_err_o return to 0.
- Inputs are ignored while state != IDLE; changes to req_* mid-transaction have no effect.
- Read after write to the same address (next transaction) returns the new data.
- Reset mid-transaction:
  - Aborts immediately to IDLE.
  - A write not yet committed (reset asserted before the RESP-entry edge) is discarded.
  - No response pulse is generated.
- req_valid_i asserted during reset release: not accepted until the first edge with rst=0.
- WAIT_STATES=0 skips WAIT entirely (IDLE -> RESP -> IDLE).

Decomposition:
- core_pkg (shared):
  - existing op_type and result_src_t enums
  - new dmem_state_t {IDLE, WAIT, RESP}
  - constant DMEM_WORD_BYTES=4
  - function dmem_addr_err(addr, aw)
- Sub-module dmem_array: single-port synchronous RAM (ADDR_WIDTH, DATA_WIDTH), with ports clk, we, idx, wdata, rdata (registered read). No reset. It is the only memory storage; the responder owns the FSM and the error logic.

Test Plan:
- Reset: hold rst=1 for 3 cycles with req_valid_i=1 -> req_ready_o=1, rsp_valid_o=0, busy_o=0 throughout; no accept until after release.
- Write/read, WAIT_STATES=2:
  - Write 0xDEADBEEF to addr 0x10, accepted at cycle T -> rsp_valid_o pulses at T+3 with rdata=0, err=0.
  - Read 0x10 -> rsp_rdata_o=0xDEADBEEF, err=0.
- Misaligned: write 0x11 -> rsp_err_o=1. Subsequent read of 0x10 still returns 0xDEADBEEF, and rdata on the errored response is 0.
- Out of range (ADDR_WIDTH=10): read 0x1000 -> rsp_err_o=1, rsp_rdata_o=0. Read 0xFFC -> err=0.
- Back-to-back: req_valid_i held high for 3 reads -> accepts spaced exactly WAIT_STATES+2=4 cycles apart; req_ready_o=0 during WAIT/RESP; exactly 3 rsp_valid_o pulses.
- Abort:
  - Start a write of 0x12345678 to 0x20; assert rst in WAIT -> no response pulse, immediate IDLE.
  - Read 0x20 afterwards -> returns the prior value (not 0x12345678).
  - Repeat the write and read with WAIT_STATES=0 to confirm 1-cycle latency.
